// File: rtl/xor_share_sched_if.sv
// Handshake bundle between the requesters, the consumer and xor_share_sched.
// Request side is per-lane packed; the response side carries the owner tag.
interface xor_share_sched_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_y;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_y
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_y
    );
endinterface

// File: rtl/xor_share_sched.sv
// Round-robin arbiter sharing one registered XOR stage between NREQ lanes.
// One operation in flight at a time: IDLE -> EXEC -> RESP -> IDLE.
module xor_share_sched #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    xor_share_sched_if.slave   bus,
    output logic               busy,
    output logic [7:0]         op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [IDW-1:0]   last_grant;
    logic [IDW-1:0]   cur_id;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    logic             found;
    logic [IDW-1:0]   win;
    logic [NREQ-1:0]  grant;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    // Scan starts one past the last winner so priority rotates.
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        grant = '0;
        sel_a = '0;
        sel_b = '0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_grant) + k) % NREQ;
            if (!found && bus.req_valid[idx]) begin
                found      = 1'b1;
                win        = IDW'(idx);
                grant[idx] = 1'b1;
                sel_a      = bus.req_a[idx*WIDTH +: WIDTH];
                sel_b      = bus.req_b[idx*WIDTH +: WIDTH];
            end
        end
    end

    assign bus.req_ready = (state == IDLE && rst_n) ? grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_grant    <= IDW'(NREQ - 1);
            cur_id        <= '0;
            op_a          <= '0;
            op_b          <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_y     <= '0;
            bus.rsp_id    <= '0;
            busy          <= 1'b0;
            op_count      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        op_a       <= sel_a;
                        op_b       <= sel_b;
                        cur_id     <= win;
                        last_grant <= win;
                        busy       <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    bus.rsp_y     <= op_a ^ op_b;
                    bus.rsp_id    <= cur_id;
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        op_count      <= op_count + 8'd1;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
